// File: rtl/hull_fifo.sv
// rtl/hull_fifo.sv - single-clock FIFO with show-ahead or registered read, registered flags
// Optional HULL_FIFO_USEDW_EN adds usedw and almost_full outputs.
module hull_fifo #(
    parameter int TYPE      = 0,
    parameter int WIDTH     = 64,
    parameter int LOG_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 wrreq,
    input  logic [WIDTH-1:0]     data,
    output logic                 full,
    input  logic                 rdreq,
    output logic [WIDTH-1:0]     q,
`ifdef HULL_FIFO_USEDW_EN
    output logic [LOG_DEPTH:0]   usedw,
    output logic                 almost_full,
`endif
    output logic                 empty
);

    localparam int                 DEPTH   = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] DEPTH_C = {1'b1, {LOG_DEPTH{1'b0}}};
    localparam logic [LOG_DEPTH:0] ONE_C   = {{LOG_DEPTH{1'b0}}, 1'b1};
    localparam logic [LOG_DEPTH-1:0] ONE_P = {{(LOG_DEPTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q;
    logic [LOG_DEPTH-1:0] rd_ptr_q;
    logic [LOG_DEPTH:0]   count_q;
    logic [LOG_DEPTH:0]   count_d;
    logic                 empty_q;
    logic                 full_q;
    logic                 wr_ok;
    logic                 rd_ok;

    // Acceptance depends only on registered flags, so wrreq/rdreq never reach full/empty combinationally.
    assign wr_ok = wrreq & ~full_q;
    assign rd_ok = rdreq & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + ONE_P;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + ONE_P;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == DEPTH_C);
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (wr_ok) mem[wr_ptr_q] <= data;
    end

    generate
        if (TYPE == 1) begin : g_normal
            logic [WIDTH-1:0] rdata_q;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) rdata_q <= '0;
                else if (rd_ok) rdata_q <= mem[rd_ptr_q];
            end
            assign q = rdata_q;
        end else begin : g_showahead
            // Head entry is presented directly; forced to zero while empty so reset leaves q = 0.
            assign q = empty_q ? '0 : mem[rd_ptr_q];
        end
    endgenerate

    assign full  = full_q;
    assign empty = empty_q;

`ifdef HULL_FIFO_USEDW_EN
    logic almost_full_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) almost_full_q <= 1'b0;
        else          almost_full_q <= (count_d >= (DEPTH_C - ONE_C));
    end
    assign usedw       = count_q;
    assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_hull_fifo.sv
// tb/tb_hull_fifo.sv - scoreboard bench for hull_fifo (show-ahead 64b and registered-read 128b)
module tb_hull_fifo;

    localparam int DEPTH = 16;

    logic          clock;
    logic          reset_n;
    logic          wrreq;
    logic          rdreq;
    logic [63:0]   data;
    logic [127:0]  data1;
    logic [63:0]   q0;
    logic [127:0]  q1;
    logic          full0, empty0, full1, empty1;
`ifdef HULL_FIFO_USEDW_EN
    logic [4:0]    usedw0, usedw1;
    logic          af0, af1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0]  mq[$];
    logic [127:0] exp1;

    assign data1 = {~data, data};

    hull_fifo #(.TYPE(0), .WIDTH(64), .LOG_DEPTH(4)) dut0 (
        .clock(clock), .reset_n(reset_n), .wrreq(wrreq), .data(data), .full(full0),
        .rdreq(rdreq), .q(q0),
`ifdef HULL_FIFO_USEDW_EN
        .usedw(usedw0), .almost_full(af0),
`endif
        .empty(empty0));

    hull_fifo #(.TYPE(1), .WIDTH(128), .LOG_DEPTH(4)) dut1 (
        .clock(clock), .reset_n(reset_n), .wrreq(wrreq), .data(data1), .full(full1),
        .rdreq(rdreq), .q(q1),
`ifdef HULL_FIFO_USEDW_EN
        .usedw(usedw1), .almost_full(af1),
`endif
        .empty(empty1));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue, popped on an accepted read and pushed on an accepted write.
    initial begin
        bit w_ok, r_ok;
        exp1 = '0;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                exp1 = '0;
            end else begin
                w_ok = wrreq && (mq.size() < DEPTH);
                r_ok = rdreq && (mq.size() > 0);
                if (r_ok) begin
                    exp1 = {~mq[0], mq[0]};
                    void'(mq.pop_front());
                end
                if (w_ok) mq.push_back(data);
            end
        end
    end

    // Monitor: compares every presented output against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                chk("empty0", {127'b0, empty0}, {127'b0, mq.size() == 0});
                chk("full0",  {127'b0, full0},  {127'b0, mq.size() == DEPTH});
                chk("empty1", {127'b0, empty1}, {127'b0, mq.size() == 0});
                chk("full1",  {127'b0, full1},  {127'b0, mq.size() == DEPTH});
                if (mq.size() > 0) chk("q0_head", {64'b0, q0}, {64'b0, mq[0]});
                chk("q1_hold", q1, exp1);
`ifdef HULL_FIFO_USEDW_EN
                chk("usedw0", {123'b0, usedw0}, 128'(mq.size()));
                chk("usedw1", {123'b0, usedw1}, 128'(mq.size()));
                chk("af0", {127'b0, af0}, {127'b0, mq.size() >= DEPTH - 1});
                chk("af1", {127'b0, af1}, {127'b0, mq.size() >= DEPTH - 1});
`endif
            end
        end
    end

    task automatic step(input logic w, input logic [63:0] d, input logic r);
        wrreq = w;
        data  = d;
        rdreq = r;
        @(posedge clock);
        #2;
    endtask

    initial begin
        int pw, pr;
        reset_n = 1'b0;
        wrreq = 1'b0;
        rdreq = 1'b0;
        data  = '0;
        repeat (3) step(1'b0, 64'h0, 1'b0);
        chk("rst_empty", {127'b0, empty0}, 128'd1);
        chk("rst_full",  {127'b0, full0},  128'd0);
        chk("rst_q0",    {64'b0, q0},      128'd0);
        chk("rst_q1",    q1,               128'd0);
        reset_n = 1'b1;
        step(1'b0, 64'h0, 1'b0);

        step(1'b1, 64'h11, 1'b0);
        chk("wr1_empty", {127'b0, empty0}, 128'd0);
        chk("wr1_q0", {64'b0, q0}, 128'h11);
        step(1'b0, 64'h0, 1'b1);
        chk("rd1_empty", {127'b0, empty0}, 128'd1);

        for (int i = 1; i <= 16; i++) step(1'b1, 64'(i), 1'b0);
        chk("fill_full", {127'b0, full0}, 128'd1);
        step(1'b1, 64'd99, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_q0", {64'b0, q0}, 128'(i));
            step(1'b0, 64'h0, 1'b1);
        end
        chk("drain_empty", {127'b0, empty0}, 128'd1);

        repeat (3) step(1'b0, 64'h0, 1'b1);
        step(1'b1, 64'hA5, 1'b1);
        chk("under_q0", {64'b0, q0}, 128'hA5);
        chk("under_empty", {127'b0, empty0}, 128'd0);
        step(1'b0, 64'h0, 1'b1);
        chk("under_pop", {127'b0, empty0}, 128'd1);

        for (int i = 0; i < 16; i++) step(1'b1, 64'(100 + i), 1'b0);
        step(1'b1, 64'd77, 1'b1);
        chk("full_both_full", {127'b0, full0}, 128'd0);
        repeat (7) step(1'b0, 64'h0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, {32'b0, $urandom}, 1'b1);
        chk("half_size", 128'(mq.size()), 128'd8);
        repeat (10) step(1'b0, 64'h0, 1'b1);

        for (int i = 0; i < 3; i++) step(1'b1, 64'(200 + i), 1'b0);
        step(1'b0, 64'h0, 1'b1);
        chk("t1_q1", q1, {~64'd200, 64'd200});
        repeat (2) step(1'b0, 64'h0, 1'b0);
        chk("t1_hold", q1, {~64'd200, 64'd200});
        repeat (2) step(1'b0, 64'h0, 1'b1);

        for (int i = 0; i < 5; i++) step(1'b1, 64'(300 + i), 1'b0);
        #1 reset_n = 1'b0;
        #1;
        chk("async_empty", {127'b0, empty0}, 128'd1);
        chk("async_full",  {127'b0, full0},  128'd0);
        chk("async_q0",    {64'b0, q0},      128'd0);
        chk("async_empty1", {127'b0, empty1}, 128'd1);
        step(1'b0, 64'h0, 1'b0);
        reset_n = 1'b1;
        step(1'b1, 64'h5A, 1'b0);
        chk("post_rst_q0", {64'b0, q0}, 128'h5A);

        for (int ph = 0; ph < 8; ph++) begin
            pw = $urandom_range(15, 95);
            pr = $urandom_range(15, 95);
            for (int i = 0; i < 100; i++)
                step($urandom_range(0, 99) < pw, {$urandom, $urandom}, $urandom_range(0, 99) < pr);
        end
        repeat (20) step(1'b0, 64'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hull_fifo.md
Name: hull_fifo

Overview:
- Parameterised synchronous single-clock FIFO used as the elastic store between burst-read unpackers and the PageRank datapath.
- Examples: vertex pairs at 128 bits; in-edge IDs at 64 bits.
- Full and empty flags are registered. TYPE selects the read mode: show-ahead (first-word fall-through) or registered-read.
- Capacity is exactly 2^LOG_DEPTH entries.

Parameters:
- TYPE, 0, read mode: 0 = show-ahead (q always presents the head entry while !empty); 1 = normal (q updates the cycle after an accepted rdreq).
- WIDTH, 64, data width in bits (>=1).
- LOG_DEPTH, 4, log2 of the entry count; depth = 2^LOG_DEPTH (>=1).

Ports:
- clock  input  1  rising-edge clock for all state.
- reset_n  input  1  asynchronous active-low reset.
- wrreq  input  1  write request; accepted only when !full.
- data  input  WIDTH  write data, captured on an accepted write.
- full  output  1  high when the FIFO holds 2^LOG_DEPTH entries.
- rdreq  input  1  read/pop request; accepted only when !empty.
- q  output  WIDTH  read data.
- empty  output  1  high when the FIFO holds 0 entries.

Behaviour:
- Storage: 2^LOG_DEPTH x WIDTH array.
  - Read and write pointers are LOG_DEPTH bits, wrapping modulo depth.
  - An occupancy counter of LOG_DEPTH+1 bits runs 0..2^LOG_DEPTH.
- Reset (reset_n low, asynchronous, takes effect immediately with no clock edge):
  - pointers = 0, count = 0, empty = 1, full = 0, q = 0.
  - Array contents are not cleared.
  - Reset mid-operation discards all entries. The first accepted write after release lands in slot 0.
- Write acceptance: wr_ok = wrreq & !full.
  - When full, wrreq is ignored even if rdreq is accepted in the same cycle. No overwrite and no error.
- Read acceptance: rd_ok = rdreq & !empty. rdreq while empty is ignored; pointers and count are unchanged.
- Count update per rising edge: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- Flags derive from the next count: empty = (count == 0), full = (count == 2^LOG_DEPTH). Both are registered and valid the cycle after the causing edge.
- TYPE 0 (show-ahead):
  - q equals the array entry at the read pointer whenever !empty. q is undefined while empty.
  - Write-to-read latency is 1 cycle: data written at edge N is visible on q with empty = 0 after edge N.
  - An rd_ok at edge N moves q to the next entry after edge N.
- TYPE 1 (normal):
  - q is a register loaded with the head entry on rd_ok; q holds its value otherwise.
  - Read latency is 1 cycle after the accepted rdreq.
- Simultaneous wr_ok and rd_ok on a non-empty, non-full FIFO: both happen and occupancy is unchanged.
- Pointer wrap: after 2^LOG_DEPTH writes the write pointer returns to 0 with ordering preserved. Strict FIFO order always.
- No combinational path from wrreq/rdreq to full/empty.
- Any TYPE value other than 0 or 1 behaves as TYPE 0.

Optional Feature:
- Macro: HULL_FIFO_USEDW_EN.
- When defined:
  - Adds output port usedw [LOG_DEPTH:0], equal to the registered occupancy count (0 after reset, 2^LOG_DEPTH when full).
  - Adds output almost_full, high when count >= 2^LOG_DEPTH - 1.
  - Both update on the same edge as the flags.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset then idle (WIDTH=64, LOG_DEPTH=4, TYPE=0) -> empty=1, full=0, q=0. Assert reset_n low mid-stream with 5 entries -> empty=1 immediately, with no clock edge.
- Write 0x11 once, no rdreq -> next cycle empty=0, q=0x11. Pulse rdreq -> next cycle empty=1.
- Write 16 values 1..16 back-to-back -> full=1 after the 16th edge. A 17th wrreq (value 99) is dropped. Reads then return 1..16 in order, and empty=1 after the 16th read.
- rdreq held high with empty FIFO for 3 cycles, then write 0xA5 -> no underflow. Count reaches 1, then the pop occurs the cycle after q=0xA5 appears.
- Full FIFO with wrreq=1 and rdreq=1 together -> read accepted, write dropped, count=15, full=0. Half-full (8) with both high for 20 cycles -> count stays 8, data order preserved across pointer wrap.
- TYPE=1, WIDTH=128: write 3 entries, rdreq one cycle -> q shows entry 0 one cycle later and holds until the next accepted read. With HULL_FIFO_USEDW_EN, usedw tracks 3 -> 2; almost_full=1 at 15.
